// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between instruction fetch and
// the load/store stage. One transaction is outstanding at a time. Data
// accesses win ties, except that a fetch is forced through after STARVE_MAX
// back-to-back data grants taken while a fetch was waiting.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // fetch requester
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  // pipeline stalls
  output logic              stall_F,
  output logic              stall_M
);

  // A zero STARVE_MAX still needs a one-bit counter to stay legal.
  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             fetch_wins;

  // Fetch takes the grant when it is alone, or when data has already
  // been granted the maximum number of times in a row while it waited.
  assign fetch_wins = i_req & (~d_req | (starve_cnt == CNT_MAX));

  // Stalls follow the requests combinationally and clear on the valid pulse.
  assign stall_F = i_req & ~i_valid;
  assign stall_M = d_req & ~d_valid;

  // Arbitration FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_wins) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= i_addr;
            starve_cnt <= '0;
            state      <= BUSY_I;
          end else if (d_req) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (!i_req)
              starve_cnt <= '0;
            else if (starve_cnt != CNT_MAX)
              starve_cnt <= starve_cnt + CNT_W'(1);
            state <= BUSY_D;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            i_rdata <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            i_valid <= 1'b1;
            state   <= DONE_I;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            // Stores leave the load data register untouched.
            if (!mem_we)
              d_rdata <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_valid <= 1'b1;
            state   <= DONE_D;
          end
        end
        // The valid cycle ignores requests so a still-held request is not
        // reissued before the stage has had a chance to drop it.
        DONE_I, DONE_D: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by a randomized
// phase checked cycle by cycle against a transaction-level model of the
// arbiter and a small word memory.
module tb_mem_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int STARVE   = 4;
  localparam int PH_FREE  = 0;
  localparam int PH_BUSY  = 1;
  localparam int PH_VALID = 2;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_valid;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          stall_F;
  logic          stall_M;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] ram [0:63];
  int            ph, ph_n, own, m_starve, n_wait;
  logic [AW-1:0] t_addr, tmp_addr;
  logic          t_we, i_flushed;
  logic [DW-1:0] t_wd, exp_i, exp_d;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .STARVE_MAX(STARVE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_rdata(i_rdata),
    .i_valid(i_valid),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_valid(d_valid),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .stall_F(stall_F),
    .stall_M(stall_M)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a      = $urandom;
    a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    // ---------------- reset with both requests high ----------------
    reset_n = 1'b0;
    i_req   = 1'b1;
    d_req   = 1'b1;
    tick();
    tick();
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check1("rst_i_valid", i_valid, 1'b0);
    check1("rst_d_valid", d_valid, 1'b0);
    check32("rst_i_rdata", i_rdata, 32'h0);
    check32("rst_d_rdata", d_rdata, 32'h0);
    check1("rst_stall_F", stall_F, 1'b1);
    check1("rst_stall_M", stall_M, 1'b1);
    i_req   = 1'b0;
    d_req   = 1'b0;
    reset_n = 1'b1;
    tick();

    // ---------------- zero-wait fetch ----------------
    i_req  = 1'b1;
    i_addr = 32'h0000_0040;
    #1;
    check1("zw_c0_stall_F", stall_F, 1'b1);
    tick();
    check1("zw_c1_mem_req", mem_req, 1'b1);
    check32("zw_c1_mem_addr", mem_addr, 32'h0000_0040);
    check1("zw_c1_mem_we", mem_we, 1'b0);
    check1("zw_c1_stall_F", stall_F, 1'b1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h2010_0005;
    tick();
    check1("zw_c2_mem_req", mem_req, 1'b0);
    check1("zw_c2_i_valid", i_valid, 1'b1);
    check32("zw_c2_i_rdata", i_rdata, 32'h2010_0005);
    check1("zw_c2_stall_F", stall_F, 1'b0);
    mem_ack = 1'b0;
    i_req   = 1'b0;
    tick();
    check1("zw_c3_i_valid", i_valid, 1'b0);

    // ---------------- tie: data first, then fetch ----------------
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0100;
    i_req  = 1'b1;
    i_addr = 32'h0000_0044;
    tick();
    check1("tie_c1_mem_req", mem_req, 1'b1);
    check32("tie_c1_mem_addr", mem_addr, 32'h0000_0100);
    check1("tie_c1_stall_F", stall_F, 1'b1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_2222;
    tick();
    check1("tie_c2_d_valid", d_valid, 1'b1);
    check32("tie_c2_d_rdata", d_rdata, 32'h1111_2222);
    check1("tie_c2_stall_M", stall_M, 1'b0);
    check1("tie_c2_stall_F", stall_F, 1'b1);
    d_req   = 1'b0;
    mem_ack = 1'b0;
    tick();
    check1("tie_c3_mem_req", mem_req, 1'b0);
    check1("tie_c3_d_valid", d_valid, 1'b0);
    check1("tie_c3_stall_F", stall_F, 1'b1);
    tick();
    check1("tie_c4_mem_req", mem_req, 1'b1);
    check32("tie_c4_mem_addr", mem_addr, 32'h0000_0044);
    check1("tie_c4_stall_F", stall_F, 1'b1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h3333_4444;
    tick();
    check1("tie_c5_i_valid", i_valid, 1'b1);
    check32("tie_c5_i_rdata", i_rdata, 32'h3333_4444);
    i_req   = 1'b0;
    mem_ack = 1'b0;
    tick();

    // ---------------- wait-state store ----------------
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0200;
    d_wdata = 32'hDEAD_BEEF;
    tick();
    for (int w = 0; w < 3; w++) begin
      check1($sformatf("st_w%0d_mem_req", w), mem_req, 1'b1);
      check1($sformatf("st_w%0d_mem_we", w), mem_we, 1'b1);
      check32($sformatf("st_w%0d_mem_addr", w), mem_addr, 32'h0000_0200);
      check32($sformatf("st_w%0d_mem_wdata", w), mem_wdata, 32'hDEAD_BEEF);
      check1($sformatf("st_w%0d_d_valid", w), d_valid, 1'b0);
      if (w == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end
      tick();
    end
    check1("st_d_valid", d_valid, 1'b1);
    check32("st_d_rdata_kept", d_rdata, 32'h1111_2222);
    check1("st_mem_we_clr", mem_we, 1'b0);
    mem_ack = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    tick();
    check1("st_d_valid_once", d_valid, 1'b0);

    // ---------------- starvation guard ----------------
    i_req    = 1'b1;
    i_addr   = 32'h0000_0080;
    d_req    = 1'b1;
    d_addr   = 32'h0000_0300;
    m_starve = 0;
    for (int g = 0; g < 11; g++) begin
      // expected winner from the tie rule with fetch held continuously
      if (m_starve == STARVE) begin
        own      = OWN_I;
        m_starve = 0;
      end else begin
        own      = OWN_D;
        m_starve = m_starve + 1;
      end
      tick();
      n_wait = 0;
      while (!mem_req && n_wait < 8) begin
        tick();
        n_wait++;
      end
      check1($sformatf("sv%0d_mem_req", g), mem_req, 1'b1);
      check32($sformatf("sv%0d_grant_addr", g), mem_addr,
              (own == OWN_I) ? 32'h0000_0080 : 32'h0000_0300);
      mem_ack   = 1'b1;
      mem_rdata = 32'hA000_0000 + 32'(g);
      tick();
      check1($sformatf("sv%0d_i_valid", g), i_valid, own == OWN_I);
      check1($sformatf("sv%0d_d_valid", g), d_valid, own == OWN_D);
      mem_ack = 1'b0;
      tick();
    end

    // ---------------- reset during a data access with ack ----------------
    i_req = 1'b0;
    tick();
    check1("mr_busy_mem_req", mem_req, 1'b1);
    reset_n   = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_5555;
    tick();
    check1("mr_mem_req", mem_req, 1'b0);
    check1("mr_d_valid", d_valid, 1'b0);
    check32("mr_d_rdata", d_rdata, 32'h0);
    check32("mr_mem_addr", mem_addr, 32'h0);
    reset_n = 1'b1;
    d_req   = 1'b0;
    mem_ack = 1'b0;
    tick();
    check1("mr_after_d_valid", d_valid, 1'b0);
    i_req  = 1'b1;
    i_addr = 32'h0000_0010;
    tick();
    check1("mr_idle_grant", mem_req, 1'b1);
    mem_ack = 1'b1;
    tick();
    i_req   = 1'b0;
    mem_ack = 1'b0;
    tick();

    // ---------------- randomized traffic against the model ----------------
    for (int k = 0; k < 64; k++) ram[k] = $urandom;
    i_req     = 1'b0;
    d_req     = 1'b0;
    mem_ack   = 1'b0;
    reset_n   = 1'b0;
    tick();
    reset_n   = 1'b1;
    ph        = PH_FREE;
    own       = 0;
    m_starve  = 0;
    exp_i     = '0;
    exp_d     = '0;
    t_addr    = '0;
    t_we      = 1'b0;
    t_wd      = '0;
    i_flushed = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      // predict the effect of the coming edge from the inputs now applied
      ph_n = ph;
      if (ph == PH_FREE) begin
        if (d_req && !(i_req && m_starve == STARVE)) begin
          own      = OWN_D;
          t_addr   = d_addr;
          t_we     = d_we;
          t_wd     = d_wdata;
          m_starve = i_req ? ((m_starve < STARVE) ? m_starve + 1 : STARVE) : 0;
          ph_n     = PH_BUSY;
        end else if (i_req) begin
          own      = OWN_I;
          t_addr   = i_addr;
          t_we     = 1'b0;
          m_starve = 0;
          ph_n     = PH_BUSY;
        end
      end else if (ph == PH_BUSY) begin
        if (mem_ack) begin
          if (own == OWN_I)
            exp_i = ram[t_addr[7:2]];
          else if (!t_we)
            exp_d = ram[t_addr[7:2]];
          else
            ram[t_addr[7:2]] = t_wd;
          ph_n = PH_VALID;
        end
      end else begin
        ph_n = PH_FREE;
      end

      tick();
      ph = ph_n;

      check1($sformatf("r%0d_mem_req", cyc), mem_req, ph == PH_BUSY);
      if (ph == PH_BUSY) begin
        check32($sformatf("r%0d_mem_addr", cyc), mem_addr, t_addr);
        check1($sformatf("r%0d_mem_we", cyc), mem_we, t_we);
        if (own == OWN_D)
          check32($sformatf("r%0d_mem_wdata", cyc), mem_wdata, t_wd);
      end else begin
        check1($sformatf("r%0d_mem_we_idle", cyc), mem_we, 1'b0);
      end
      check1($sformatf("r%0d_i_valid", cyc), i_valid, ph == PH_VALID && own == OWN_I);
      check1($sformatf("r%0d_d_valid", cyc), d_valid, ph == PH_VALID && own == OWN_D);
      check32($sformatf("r%0d_i_rdata", cyc), i_rdata, exp_i);
      check32($sformatf("r%0d_d_rdata", cyc), d_rdata, exp_d);
      check1($sformatf("r%0d_stall_F", cyc), stall_F,
             i_req && !(ph == PH_VALID && own == OWN_I));
      check1($sformatf("r%0d_stall_M", cyc), stall_M,
             d_req && !(ph == PH_VALID && own == OWN_D));

      // memory responder: random wait states, data from the model memory
      mem_ack = 1'b0;
      if (ph == PH_BUSY) begin
        mem_ack   = ($urandom_range(0, 2) != 0);
        mem_rdata = ram[mem_addr[7:2]];
      end else begin
        mem_rdata = $urandom;
      end

      // fetch stage: holds until valid, occasionally flushed mid-access
      if (i_flushed) begin
        if (ph == PH_VALID && own == OWN_I) i_flushed = 1'b0;
      end else if (i_req) begin
        if (ph == PH_VALID && own == OWN_I) begin
          if ($urandom_range(0, 1) == 1) begin
            tmp_addr = rand_addr();
            i_addr   = tmp_addr;
          end else begin
            i_req = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          i_req = 1'b0;
          if (ph == PH_BUSY && own == OWN_I) i_flushed = 1'b1;
        end
      end else if ($urandom_range(0, 1) == 1) begin
        i_req    = 1'b1;
        tmp_addr = rand_addr();
        i_addr   = tmp_addr;
      end

      // memory stage: random loads and stores, held until valid
      if (d_req) begin
        if (ph == PH_VALID && own == OWN_D) begin
          if ($urandom_range(0, 1) == 1) begin
            tmp_addr = rand_addr();
            d_addr   = tmp_addr;
            d_we     = $urandom_range(0, 1) == 1;
            d_wdata  = $urandom;
          end else begin
            d_req = 1'b0;
          end
        end
      end else if ($urandom_range(0, 1) == 1) begin
        d_req    = 1'b1;
        tmp_addr = rand_addr();
        d_addr   = tmp_addr;
        d_we     = $urandom_range(0, 1) == 1;
        d_wdata  = $urandom;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (lw/sw).
- Serialises accesses and produces stall_F/stall_M, which the hazard logic ORs into its stall terms.
- Data accesses win ties (older instruction); a bounded starvation guard guarantees fetch progress.
- Memory side is a variable-latency req/ack handshake.

Parameters:
- ADDR_W, 32, address width for both requesters and memory.
- DATA_W, 32, data width.
- STARVE_MAX, 4, maximum consecutive data grants allowed while a fetch is pending (0 = fetch wins every tie).

Ports:
- clk  in  1  clock; everything updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- i_req  in  1  fetch request; held until i_valid.
- i_addr  in  ADDR_W  fetch address (word-aligned).
- i_rdata  out  DATA_W  fetched instruction; registered.
- i_valid  out  1  one-cycle pulse: fetch complete.
- d_req  in  1  data request; held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; registered.
- d_valid  out  1  one-cycle pulse: data access complete.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; sampled when mem_ack=1.
- mem_ack  in  1  memory completion; may be asserted in the first cycle of mem_req.
- stall_F  out  1  fetch stall.
- stall_M  out  1  memory-stage stall.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE, starve_cnt=0.
  - All registered outputs =0: mem_req, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, i_valid, d_valid.
  - An outstanding memory transaction is abandoned, with no valid pulse. The memory must tolerate mem_req dropping.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE, arbitration at the edge:
  - d_req & i_req & starve_cnt==STARVE_MAX → grant I.
  - Otherwise d_req → grant D.
  - Otherwise i_req → grant I.
  - Otherwise stay in IDLE.
- Grant effects:
  - Grant D: latch d_addr/d_we/d_wdata into mem_addr/mem_we/mem_wdata → BUSY_D.
  - Grant I: latch i_addr into mem_addr, mem_we=0, mem_wdata unchanged → BUSY_I.
- BUSY_x:
  - mem_req=1; mem_addr/mem_we/mem_wdata stay stable until ack.
  - mem_ack=1 at an edge → capture mem_rdata into x_rdata (D only if mem_we=0; stores leave d_rdata unchanged) → DONE_x, mem_req=0, mem_we=0.
- DONE_x:
  - x_valid=1 for exactly this cycle; requests are ignored → IDLE.
  - Ignoring requests here prevents reissuing a request the stage has not yet dropped.
- Latency:
  - Request seen in IDLE at cycle t → mem_req from t+1.
  - Ack at cycle t+k (k≥1) → valid at t+k+1.
  - Minimum 2 cycles from request to valid; next grant is possible at t+k+2.
- Stalls (combinational):
  - stall_F = i_req & ~i_valid.
  - stall_M = d_req & ~d_valid.
- Starvation counter (width $clog2(STARVE_MAX+1)), updated at each grant:
  - D grant with i_req=1 → starve_cnt+1 (saturating at STARVE_MAX).
  - D grant with i_req=0 → 0.
  - I grant → 0.
- Requester drops its req mid-transaction (e.g. fetch flushed by a branch): the transaction completes normally and the valid pulse still fires; the requester ignores it.
- Only one transaction is outstanding at a time; i_valid and d_valid are never high in the same cycle.
- reset_n=0 overrides everything, including mem_ack in the same cycle.

Test Plan:
- Reset: hold reset_n=0 with i_req=d_req=1 → mem_req=0, i_valid=d_valid=0, i_rdata=d_rdata=0. stall_F=stall_M=1 (combinational on req).
- Zero-wait fetch:
  - Stimulus: i_req at cycle 0, i_addr=0x0000_0040; mem_ack=1 at cycle 1, mem_rdata=0x2010_0005.
  - Required: mem_req=1 at cycle 1 only; i_valid=1 at cycle 2 with i_rdata=0x2010_0005; stall_F=1 in cycles 0–1, 0 in cycle 2.
- Tie:
  - Stimulus: cycle 0 d_req (load, d_addr=0x100) and i_req (i_addr=0x44); one-cycle acks.
  - Required: mem_addr=0x100 first, d_valid at cycle 2; I granted at cycle 3, i_valid at cycle 5; stall_F held through cycle 4.
- Wait-state store:
  - Stimulus: d_we=1, d_addr=0x200, d_wdata=0xDEAD_BEEF; mem_ack delayed 3 cycles.
  - Required: mem_we/mem_addr/mem_wdata constant over all 3 cycles; d_valid pulses once; d_rdata keeps its prior value.
- Starvation: STARVE_MAX=4, d_req and i_req held continuously → grant order D,D,D,D,I,D…; starve_cnt returns to 0 after the I grant.
- Mid-op reset: reset_n=0 during BUSY_D with mem_ack=1 in the same cycle → next cycle state=IDLE, mem_req=0, no d_valid, d_rdata=0.
